alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits, even, at least 8.
REQ-002 Parameter SH_W, default $clog2(WIDTH): shift-amount width, derived.
REQ-003 clk  in  1: single clock, rising edge.
REQ-004 reset  in  1: asynchronous, active-low reset.
REQ-005 a  in  WIDTH: operand A (rs).
REQ-006 b  in  WIDTH: operand B (rt).
REQ-007 aluop  in  6: operation select, MIPS funct encoding.
REQ-008 shamt  in  SH_W: shift amount.
REQ-009 start  in  1: launch request for HI/LO-writing operations.
REQ-010 result  out  WIDTH: combinational result of the current aluop.
REQ-011 zero  out  1: high when result is all zeros.
REQ-012 busy  out  1: high while an iterative multiply or divide is in progress.
REQ-013 done  out  1: single-cycle pulse when HI/LO is updated by a multiply or divide.

Function
REQ-014 Combinational ops, valid in the same cycle: add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, slt 101010 (signed, 1/0), sltu 101011, sll 000000, srl 000010, sra 000011.
REQ-015 mfhi 010000 / mflo 010010 drive HI / LO onto result; while busy they return pre-operation values.
REQ-016 mthi 010001 / mtlo 010011 with start=1 and busy=0 write a into HI / LO at the next edge; done is not pulsed.
REQ-017 mult 011000, multu 011001, div 011010, divu 011011 with start=1 and busy=0 are accepted; a and b are latched at that edge.
REQ-018 FSM states: IDLE, RUN, DONE; IDLE->RUN on accept; RUN->DONE after exactly WIDTH iterations; DONE->IDLE unconditionally.
REQ-019 busy is high in every RUN cycle (WIDTH cycles); HI/LO are written on the RUN->DONE edge; done is high for the one DONE cycle.
REQ-020 start while busy or in DONE is ignored, and an unrecognised aluop with start is ignored; neither causes an error or a state change.
REQ-021 Multiply: 2*WIDTH-bit product, HI = upper half, LO = lower half; mult is two's-complement, multu unsigned.
REQ-022 Divide: LO = quotient, HI = remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-023 Divide by zero (either kind): LO = all ones, HI = a; latency unchanged.
REQ-024 Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
REQ-025 Combinational ops stay usable while busy and do not disturb the iteration.

Reset
REQ-026 On reset assertion, regardless of state: FSM -> IDLE, HI = LO = 0, busy = 0, done = 0, iteration counter = 0, any in-flight operation aborted with no HI/LO update.
REQ-027 Deassertion is synchronised to clk inside the block; the first accept is possible on the second rising edge after deassertion.

Configuration
REQ-028 Macro ALU_MULDIV_DIV_EN defined: div and divu are implemented per REQ-022..024.
REQ-029 ALU_MULDIV_DIV_EN undefined: the divide datapath is omitted; div/divu are never accepted; busy stays low, HI/LO are unchanged and done does not pulse; multiply is unaffected.

Structure
REQ-030 Package alu_pkg holds the aluop funct localparams and the FSM state typedef; no width-dependent content is placed in it.
REQ-031 One sub-module, alu_seq_core, holds the shared shift register, counter and add/subtract iteration datapath for multiply and divide; alu_muldiv holds the decode, combinational ops, HI/LO and the FSM.

Verification
REQ-032 multu a=FFFFFFFF b=FFFFFFFF (WIDTH 32) -> busy 32 cycles, done at cycle 33, HI=FFFFFFFE LO=00000001.
REQ-033 mult a=FFFFFFFD b=00000005 -> HI=FFFFFFFF LO=FFFFFFF1; div a=FFFFFFF9 b=00000002 -> LO=FFFFFFFD HI=FFFFFFFF.
REQ-034 divu a=5 b=0 -> LO=FFFFFFFF HI=00000005; div a=80000000 b=FFFFFFFF -> LO=80000000 HI=0.
REQ-035 Reset asserted at RUN cycle 10 of a mult -> busy=0, done never pulses, mfhi/mflo return 0.
REQ-036 Second multu start at RUN cycle 5 with different operands -> ignored; the first result lands unchanged; mflo during RUN returns the prior LO.
REQ-037 Combinational ops: sra a=x b=80000000 shamt=4 -> F8000000; sltu a=1 b=FFFFFFFF -> 1 with zero=0; sub a=7 b=7 -> 0 with zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: funct encodings and FSM state type shared by the
// alu_muldiv top and its iterative multiply/divide core.
package alu_pkg;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_seq_core.sv
// alu_seq_core: shared shift register, counter and add/sub step
// for unsigned multiply and (with ALU_MULDIV_DIV_EN) divide.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
`ifdef ALU_MULDIV_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt,
  output logic             last
);

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [CNT_W-1:0] cnt;

  assign last = (cnt == CNT_W'(WIDTH - 1));

`ifdef ALU_MULDIV_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   op_a;
  logic [WIDTH:0]   op_b;
  logic [WIDTH+1:0] sum;
  logic             ge;

  // one adder: shift-add for multiply, trial subtract for divide
  always_comb begin
    op_a = div_q ? {hi_r, lo_r[WIDTH-1]} : {1'b0, hi_r};
    op_b = div_q ? ~{1'b0, x_q}
                 : (lo_r[0] ? {1'b0, x_q} : '0);
    sum  = {1'b0, op_a} + {1'b0, op_b}
         + {{(WIDTH+1){1'b0}}, div_q};
    ge   = sum[WIDTH+1];
    if (div_q) begin
      hi_nxt = ge ? sum[WIDTH-1:0] : op_a[WIDTH-1:0];
      lo_nxt = {lo_r[WIDTH-2:0], ge};
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo_r[WIDTH-1:1]};
    end
  end
`else
  logic [WIDTH:0] sum;

  // shift-add multiply step
  always_comb begin
    sum    = {1'b0, hi_r}
           + (lo_r[0] ? {1'b0, x_q} : '0);
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], lo_r[WIDTH-1:1]};
  end
`endif

  // operand load and per-cycle iteration update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      cnt   <= '0;
`ifdef ALU_MULDIV_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (load) begin
      x_q   <= x_in;
      hi_r  <= '0;
      lo_r  <= y_in;
      cnt   <= '0;
`ifdef ALU_MULDIV_DIV_EN
      div_q <= div_mode;
`endif
    end else if (step) begin
      hi_r <= hi_nxt;
      lo_r <= lo_nxt;
      cnt  <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS funct ALU plus iterative HI/LO mult/div.
// Define ALU_MULDIV_DIV_EN to build the div/divu datapath.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       aluop,
  input  logic [SH_W-1:0]  shamt,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic             rst_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             is_mul;
  logic             is_div;
  logic             is_sgn;
  logic             launch;
  logic             last;
  logic             sa;
  logic             sb;
  logic             neg_lo;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;
  logic [2*WIDTH-1:0] prod;
`ifdef ALU_MULDIV_DIV_EN
  logic             op_div;
  logic             neg_hi;
  logic             div0;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
`endif

  // async assert, release on the first clock after deassertion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_q <= 1'b0;
    else        rst_q <= 1'b1;
  end

  assign is_mul = (aluop == F_MULT) || (aluop == F_MULTU);
`ifdef ALU_MULDIV_DIV_EN
  assign is_div = (aluop == F_DIV) || (aluop == F_DIVU);
`else
  assign is_div = 1'b0;
`endif
  assign is_sgn = (aluop == F_MULT) || (aluop == F_DIV);
  assign launch = start && (state == IDLE) && (is_mul || is_div);

  assign sa    = is_sgn & a[WIDTH-1];
  assign sb    = is_sgn & b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

`ifdef ALU_MULDIV_DIV_EN
  assign x_in = is_div ? mag_b : mag_a;
  assign y_in = is_div ? mag_a : mag_b;
`else
  assign x_in = mag_a;
  assign y_in = mag_b;
`endif

  alu_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_q),
    .load     (launch),
    .step     (state == RUN),
`ifdef ALU_MULDIV_DIV_EN
    .div_mode (is_div),
`endif
    .x_in     (x_in),
    .y_in     (y_in),
    .hi_nxt   (hi_nxt),
    .lo_nxt   (lo_nxt),
    .last     (last)
  );

  // sign fix-up and divide special cases on the final step
  always_comb begin
    prod = {hi_nxt, lo_nxt};
    if (neg_lo) prod = -prod;
    fin_hi = prod[2*WIDTH-1:WIDTH];
    fin_lo = prod[WIDTH-1:0];
`ifdef ALU_MULDIV_DIV_EN
    quo = neg_lo ? -lo_nxt : lo_nxt;
    rem = neg_hi ? -hi_nxt : hi_nxt;
    if (op_div) begin
      fin_hi = div0 ? a_q : rem;
      fin_lo = div0 ? '1 : quo;
    end
`endif
  end

  // FSM, HI/LO and registered busy/done
  always_ff @(posedge clk or negedge rst_q) begin
    if (!rst_q) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_lo <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      op_div <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      a_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              launch: begin
                state  <= RUN;
                busy   <= 1'b1;
                neg_lo <= sa ^ sb;
`ifdef ALU_MULDIV_DIV_EN
                op_div <= is_div;
                neg_hi <= sa;
                div0   <= (b == '0);
                a_q    <= a;
`endif
              end
              (aluop == F_MTHI): hi_q <= a;
              (aluop == F_MTLO): lo_q <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi_q  <= fin_hi;
            lo_q  <= fin_lo;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // combinational result select
  always_comb begin
    result = '0;
    case (aluop)
      F_ADD:   result = a + b;
      F_SUB:   result = a - b;
      F_AND:   result = a & b;
      F_OR:    result = a | b;
      F_XOR:   result = a ^ b;
      F_NOR:   result = ~(a | b);
      F_SLT:   result = {{(WIDTH-1){1'b0}},
                         $signed(a) < $signed(b)};
      F_SLTU:  result = {{(WIDTH-1){1'b0}}, a < b};
      F_SLL:   result = b << shamt;
      F_SRL:   result = b >> shamt;
      F_SRA:   result = $signed(b) >>> shamt;
      F_MFHI:  result = hi_q;
      F_MFLO:  result = lo_q;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: randomized self-checking bench for alu_muldiv
// against an arithmetic reference model (WIDTH 32).
module tb_alu_muldiv;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [5:0]  aluop = F_ADD;
  logic [4:0]  shamt = '0;
  logic        start = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .aluop  (aluop),
    .shamt  (shamt),
    .start  (start),
    .result (result),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_comb(
    input logic [5:0] op, input logic [31:0] x,
    input logic [31:0] y, input logic [4:0] s);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      F_ADD:  return x + y;
      F_SUB:  return x - y;
      F_AND:  return x & y;
      F_OR:   return x | y;
      F_XOR:  return x ^ y;
      F_NOR:  return ~(x | y);
      F_SLT:  return (sx < sy) ? 32'd1 : 32'd0;
      F_SLTU: return (x < y) ? 32'd1 : 32'd0;
      F_SLL:  return y << s;
      F_SRL:  return y >> s;
      F_SRA:  return 32'(sy >>> s);
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_md(input logic [5:0] op,
    input logic [31:0] x, input logic [31:0] y,
    output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op == F_MULT) p = sx * sy;
    else if (op == F_MULTU) p = {32'd0, x} * {32'd0, y};
    else if (y == 0) p = {x, 32'hFFFF_FFFF};
    else if (op == F_DIV) begin
      q = sx / sy;
      r = sx % sy;
      p = {r[31:0], q[31:0]};
    end else p = {x % y, x / y};
    h = p[63:32];
    l = p[31:0];
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [5:0] op,
    input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    aluop = op;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit to);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    to = (done !== 1'b1);
  endtask

  task automatic read_hilo(output logic [31:0] h,
    output logic [31:0] l);
    aluop = F_MFHI;
    #1;
    h = result;
    aluop = F_MFLO;
    #1;
    l = result;
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0",
               busy, done);
    end
    read_hilo(h, l);
    checks++;
    if (h !== 32'd0 || l !== 32'd0) begin
      failures++;
      $display("FAIL reset_hilo hi=%h lo=%h want 0 0", h, l);
    end
    aluop = F_MFHI;
    #1;
    checks++;
    if (zero !== 1'b1) begin
      failures++;
      $display("FAIL reset_zero zero=%b want 1", zero);
    end
  endtask

  task automatic test_mul_directed();
    int n, nb;
    bit to;
    logic [31:0] h, l;
    launch(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL accept_after_reset busy=%b want 1", busy);
    end
    nb = 1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (busy === 1'b1) nb++;
    end
    to = (done !== 1'b1);
    checks++;
    if (to || n != 32 || nb != 32) begin
      failures++;
      $display("FAIL multu_latency n=%0d busy=%0d want 32 32",
               n, nb);
    end
    read_hilo(h, l);
    checks++;
    if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin
      failures++;
      $display("FAIL multu_max hi=%h lo=%h want fffffffe 1",
               h, l);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse done=%b busy=%b want 0 0",
               done, busy);
    end
    launch(F_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done(n, to);
    @(posedge clk);
    #1;
    read_hilo(h, l);
    checks++;
    if (to || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFF1) begin
      failures++;
      $display("FAIL mult_neg hi=%h lo=%h want ffffffff fffffff1",
               h, l);
    end
    exp_hi = 32'hFFFF_FFFF;
    exp_lo = 32'hFFFF_FFF1;
  endtask

  task automatic test_div_directed();
    logic [31:0] h, l;
    int n;
    bit to;
`ifdef ALU_MULDIV_DIV_EN
    logic [5:0]  ops[4] = '{F_DIV, F_DIVU, F_DIV, F_DIV};
    logic [31:0] xs[4] = '{32'hFFFF_FFF9, 32'd5,
                           32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] ys[4] = '{32'd2, 32'd0,
                           32'hFFFF_FFFF, 32'd0};
    logic [31:0] eh[4] = '{32'hFFFF_FFFF, 32'd5,
                           32'd0, 32'hFFFF_FFFB};
    logic [31:0] el[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF,
                           32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], xs[i], ys[i]);
      wait_done(n, to);
      read_hilo(h, l);
      checks++;
      if (to || n != 32 || h !== eh[i] || l !== el[i]) begin
        failures++;
        $display("FAIL div_dir%0d n=%0d hi=%h lo=%h want 32 %h %h",
                 i, n, h, l, eh[i], el[i]);
      end
      @(posedge clk);
      #1;
      exp_hi = eh[i];
      exp_lo = el[i];
    end
`else
    bit seen;
    launch(F_DIV, 32'd7, 32'd2);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL div_disabled_busy busy=%b want 0", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    to = seen;
    n = 0;
    checks++;
    if (to) begin
      failures++;
      $display("FAIL div_disabled_done seen=%b want 0", seen);
    end
    read_hilo(h, l);
    checks++;
    if (h !== exp_hi || l !== exp_lo || n != 0) begin
      failures++;
      $display("FAIL div_disabled_hilo hi=%h lo=%h want %h %h",
               h, l, exp_hi, exp_lo);
    end
`endif
  endtask

  task automatic test_comb();
    logic [5:0]  ops[11] = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR,
                             F_NOR, F_SLT, F_SLTU, F_SLL,
                             F_SRL, F_SRA};
    logic [31:0] e;
    @(negedge clk);
    aluop = F_SRA; a = $urandom; b = 32'h8000_0000; shamt = 5'd4;
    #1;
    checks++;
    if (result !== 32'hF800_0000) begin
      failures++;
      $display("FAIL sra_dir got=%h want f8000000", result);
    end
    aluop = F_SLTU; a = 32'd1; b = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (result !== 32'd1 || zero !== 1'b0) begin
      failures++;
      $display("FAIL sltu_dir got=%h zero=%b want 1 0",
               result, zero);
    end
    aluop = F_SUB; a = 32'd7; b = 32'd7;
    #1;
    checks++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      failures++;
      $display("FAIL sub_zero got=%h zero=%b want 0 1",
               result, zero);
    end
    for (int i = 0; i < 60; i++) begin
      aluop = ops[$urandom_range(0, 10)];
      a = pick();
      b = pick();
      shamt = 5'($urandom);
      #1;
      e = ref_comb(aluop, a, b, shamt);
      checks++;
      if (result !== e || zero !== (e == 32'd0)) begin
        failures++;
        $display("FAIL comb op=%b a=%h b=%h s=%0d got=%h/%b want %h",
                 aluop, a, b, shamt, result, zero, e);
      end
    end
  endtask

  task automatic test_mt();
    logic [31:0] h, l, v;
    v = $urandom;
    launch(F_MTHI, v, 32'd0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi_flags done=%b busy=%b want 0 0",
               done, busy);
    end
    exp_hi = v;
    v = $urandom;
    launch(F_MTLO, v, 32'd0);
    exp_lo = v;
    read_hilo(h, l);
    checks++;
    if (h !== exp_hi || l !== exp_lo) begin
      failures++;
      $display("FAIL mt_write hi=%h lo=%h want %h %h",
               h, l, exp_hi, exp_lo);
    end
  endtask

  task automatic test_unknown();
    logic [31:0] h, l;
    launch(6'b111111, 32'd3, 32'd4);
    @(posedge clk);
    #1;
    read_hilo(h, l);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        h !== exp_hi || l !== exp_lo) begin
      failures++;
      $display("FAIL unknown_op busy=%b done=%b hi=%h lo=%h",
               busy, done, h, l);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, y1, h, l, eh, el, s;
    int n;
    bit to;
    x1 = $urandom;
    y1 = $urandom;
    ref_md(F_MULTU, x1, y1, eh, el);
    launch(F_MULTU, x1, y1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    aluop = F_MFLO;
    #1;
    checks++;
    if (result !== exp_lo) begin
      failures++;
      $display("FAIL mflo_in_run got=%h want %h", result, exp_lo);
    end
    aluop = F_ADD;
    a = $urandom;
    b = $urandom;
    #1;
    s = a + b;
    checks++;
    if (result !== s || busy !== 1'b1) begin
      failures++;
      $display("FAIL add_in_run got=%h busy=%b want %h 1",
               result, busy, s);
    end
    launch(F_MULTU, ~x1, y1 + 32'd1);
    wait_done(n, to);
    read_hilo(h, l);
    checks++;
    if (to || n != 27 || h !== eh || l !== el) begin
      failures++;
      $display("FAIL ignore_restart n=%0d hi=%h lo=%h want 27 %h %h",
               n, h, l, eh, el);
    end
    exp_hi = eh;
    exp_lo = el;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [5:0]  ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    logic [5:0]  op;
    logic [31:0] x, y, h, l, eh, el;
    int n;
    bit to;
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 3)];
      x = pick();
      y = pick();
`ifndef ALU_MULDIV_DIV_EN
      if (op == F_DIV || op == F_DIVU) begin
        launch(op, x, y);
        @(posedge clk);
        #1;
        read_hilo(h, l);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 ||
            h !== exp_hi || l !== exp_lo) begin
          failures++;
          $display("FAIL rnd_div_off busy=%b hi=%h lo=%h",
                   busy, h, l);
        end
        continue;
      end
`endif
      ref_md(op, x, y, eh, el);
      launch(op, x, y);
      wait_done(n, to);
      read_hilo(h, l);
      checks++;
      if (to || n != 32 || h !== eh || l !== el) begin
        failures++;
        $display("FAIL rnd op=%b a=%h b=%h n=%0d hi=%h lo=%h want %h %h",
                 op, x, y, n, h, l, eh, el);
      end
      exp_hi = eh;
      exp_lo = el;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_abort();
    logic [31:0] h, l;
    int n;
    bit to, seen;
    launch(F_MULT, 32'h1234_5678, 32'h8765_4321);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre busy=%b want 1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_flags busy=%b done=%b want 0 0",
               busy, done);
    end
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    if (done === 1'b1) seen = 1'b1;
    read_hilo(h, l);
    checks++;
    if (seen || h !== 32'd0 || l !== 32'd0) begin
      failures++;
      $display("FAIL abort_hilo done_seen=%b hi=%h lo=%h want 0 0 0",
               seen, h, l);
    end
    launch(F_MULTU, 32'd6, 32'd7);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL accept_after_abort busy=%b want 1", busy);
    end
    wait_done(n, to);
    read_hilo(h, l);
    checks++;
    if (to || n != 32 || h !== 32'd0 || l !== 32'd42) begin
      failures++;
      $display("FAIL post_abort n=%0d hi=%h lo=%h want 32 0 2a",
               n, h, l);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_comb();
    test_mt();
    test_unknown();
    test_back_to_back();
    test_random();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
